spi_xfer_seq: RTL and testbench

Burst transfer sequencer placed directly upstream of the `spi_master` byte engine. It buffers outgoing bytes in a TX FIFO and issues one `go` per byte, holding chip-select low across the whole burst. Received bytes are captured into an RX FIFO. The bus wrapper sees FIFO push/pop ports, a start/length command, and status flags, instead of hand-pulsing `go` for every byte.

---
 rtl/spi_seq_pkg.sv | 13 +
 rtl/spi_seq_fifo.sv | 95 +++++++++
 rtl/spi_xfer_seq.sv | 184 ++++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI burst transfer sequencer.
package spi_seq_pkg;

  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_END   = 2'd3
  } state_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with registered head, level and full/empty flags.
// The head register is kept valid whenever the FIFO is non-empty, so reads have no extra latency.
module spi_seq_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ZERO = '0;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wcnt;
  logic [AW:0]   r_rcnt;
  logic [AW:0]   r_level;
  logic [DW-1:0] r_head;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_wcnt_nxt;
  logic [AW:0]   w_rcnt_nxt;
  logic [AW:0]   w_level_nxt;
  logic [DW-1:0] w_head_nxt;

  assign w_push = i_wr & ~r_full & ~i_clr;
  assign w_pop  = i_rd & ~r_empty & ~i_clr;

  // Next counters, level and head; a push lands directly in the head when it becomes the only entry.
  always_comb begin
    w_wcnt_nxt = r_wcnt;
    w_rcnt_nxt = r_rcnt;
    if (i_clr) begin
      w_wcnt_nxt = LVL_ZERO;
      w_rcnt_nxt = LVL_ZERO;
    end else begin
      w_wcnt_nxt = r_wcnt + {{AW{1'b0}}, w_push};
      w_rcnt_nxt = r_rcnt + {{AW{1'b0}}, w_pop};
    end
    w_level_nxt = w_wcnt_nxt - w_rcnt_nxt;
    if (w_push && (r_wcnt[AW-1:0] == w_rcnt_nxt[AW-1:0])) begin
      w_head_nxt = i_wdata;
    end else begin
      w_head_nxt = r_mem[w_rcnt_nxt[AW-1:0]];
    end
  end

  // Storage array write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wcnt[AW-1:0]] <= i_wdata;
    end
  end

  // Pointer, level, flag and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= LVL_ZERO;
      r_rcnt  <= LVL_ZERO;
      r_level <= LVL_ZERO;
      r_head  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wcnt  <= w_wcnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_level <= w_level_nxt;
      r_head  <= w_head_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == LVL_ZERO);
    end
  end

  assign o_rdata = r_head;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/spi_xfer_seq.sv
// Burst sequencer in front of spi_master: drains a TX FIFO one byte per go pulse,
// captures received bytes into an RX FIFO and holds chip-select low across the burst.
module spi_xfer_seq
  import spi_seq_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    tx_data,
  input  logic             tx_wr,
  output logic             tx_full,
  output logic [AW:0]      tx_level,
  output logic [DW-1:0]    rx_data,
  input  logic             rx_rd,
  output logic             rx_empty,
  output logic [AW:0]      rx_level,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             ssn,
  output logic             spi_go,
  output logic [DW-1:0]    spi_datai,
  input  logic [DW-1:0]    spi_datao,
  input  logic             spi_done
);

  localparam logic [LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ssn;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;
  logic             r_go;
  logic [DW-1:0]    r_datai;

  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             w_ssn_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_ovr_nxt;
  logic             w_go_nxt;
  logic [DW-1:0]    w_datai_nxt;
  logic             w_tx_pop;
  logic             w_rx_push;
  logic             w_clr;
  logic             w_tx_empty;
  logic [DW-1:0]    w_tx_head;
  logic             w_rx_full;

  spi_seq_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_wr    (tx_wr),
    .i_wdata (tx_data),
    .i_rd    (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_full  (tx_full),
    .o_empty (w_tx_empty),
    .o_level (tx_level)
  );

  spi_seq_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_wr    (w_rx_push),
    .i_wdata (spi_datao),
    .i_rd    (rx_rd),
    .o_rdata (rx_data),
    .o_full  (w_rx_full),
    .o_empty (rx_empty),
    .o_level (rx_level)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ssn_nxt   = r_ssn;
    w_done_nxt  = 1'b0;
    w_ovr_nxt   = r_overrun;
    w_go_nxt    = 1'b0;
    w_datai_nxt = r_datai;
    w_tx_pop    = 1'b0;
    w_rx_push   = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_clr     = 1'b1;
          w_ovr_nxt = 1'b0;
        end else if (start && (len != LEN_ZERO)) begin
          w_cnt_nxt   = len;
          w_ssn_nxt   = 1'b0;
          w_state_nxt = S_ISSUE;
        end else begin
          w_ssn_nxt = 1'b1;
        end
      end
      S_ISSUE: begin
        // An empty TX FIFO simply stalls here with chip-select still asserted.
        if (!w_tx_empty) begin
          w_tx_pop    = 1'b1;
          w_go_nxt    = 1'b1;
          w_datai_nxt = w_tx_head;
          w_state_nxt = S_WAIT;
        end else begin
          w_ssn_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (spi_done) begin
          w_rx_push = 1'b1;
          if (w_rx_full) begin
            w_ovr_nxt = 1'b1;
          end else begin
            w_ovr_nxt = r_overrun;
          end
          w_cnt_nxt = r_cnt - LEN_ONE;
          if (r_cnt == LEN_ONE) begin
            w_state_nxt = S_END;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_END: begin
        w_ssn_nxt   = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_ssn_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= LEN_ZERO;
      r_ssn     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_go      <= 1'b0;
      r_datai   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ssn     <= w_ssn_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_overrun <= w_ovr_nxt;
      r_go      <= w_go_nxt;
      r_datai   <= w_datai_nxt;
    end
  end

  assign ssn       = r_ssn;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_overrun;
  assign spi_go    = r_go;
  assign spi_datai = r_datai;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Self-checking bench for spi_xfer_seq: hand sequences, a table of burst scenarios and
// randomized operations, all checked against a queue-based model of the FIFOs and bursts.
module tb_spi_xfer_seq;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic [2:0] tx_level;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       rx_empty;
  logic [2:0] rx_level;
  logic       start;
  logic [7:0] len;
  logic       flush;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       ssn;
  logic       spi_go;
  logic [7:0] spi_datai;
  logic [7:0] spi_datao;
  logic       spi_done;

  always #5 clk = ~clk;

  spi_xfer_seq #(.DW(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_level(tx_level),
    .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_level(rx_level),
    .start(start), .len(len), .flush(flush),
    .busy(busy), .done(done), .overrun(overrun), .ssn(ssn),
    .spi_go(spi_go), .spi_datai(spi_datai), .spi_datao(spi_datao), .spi_done(spi_done)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         ovr_m;

  typedef struct {
    bit do_flush;
    int npush;
    int blen;
    int exp_txl;
    int exp_rxl;
    bit exp_ovr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] echo(input logic [7:0] b);
    return ~b;
  endfunction

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    ovr_m = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr = 1'b1; tx_data = b;
    @(negedge clk);
    tx_wr = 1'b0;
    if (tx_q.size() < DEPTH) tx_q.push_back(b);
  endtask

  task automatic pop_rx();
    if (rx_q.size() > 0) chk("rx_data", rx_data, rx_q[0]);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    if (rx_q.size() > 0) void'(rx_q.pop_front());
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  task automatic pulse_start(input int l);
    start = 1'b1; len = l[7:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (spi_go !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Plays spi_master for one byte; called while datai of the current byte is valid.
  task automatic serve(input bit last, input int lat);
    logic [7:0] b;
    b = spi_datai;
    chk("ssn_low", ssn, 1'b0);
    if (tx_q.size() > 0) chk("datai", b, tx_q.pop_front());
    else chk("datai_unexpected", 32'h1, 32'h0);
    repeat (lat) @(negedge clk);
    chk("datai_hold", spi_datai, b);
    spi_datao = echo(b);
    spi_done  = 1'b1;
    @(negedge clk);
    spi_done  = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(echo(b));
    else ovr_m = 1'b1;
    chk("rx_level_d1", rx_level, rx_q.size());
    if (last) begin
      chk("end_cycle", {ssn, done, busy}, 3'b001);
      @(negedge clk);
      chk("end_flags", {ssn, done, busy}, 3'b110);
      @(negedge clk);
      chk("done_pulse", {done, busy}, 2'b00);
    end
  endtask

  task automatic burst(input int l);
    int n;
    pulse_start(l);
    for (int i = 0; i < l; i++) begin
      wait_go(n);
      chk("go_lat", n, 1);
      if (n >= 40) return;
      serve(i == l - 1, $urandom_range(1, 3));
    end
  endtask

  task automatic len0_check();
    bit bad;
    pulse_start(0);
    bad = spi_go | ~ssn | busy;
    repeat (3) begin
      @(negedge clk);
      bad |= spi_go | done | ~ssn | busy;
    end
    chk("len0_quiet", bad, 1'b0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_txl"}, tx_level, tx_q.size());
    chk({tag, "_rxl"}, rx_level, rx_q.size());
    chk({tag, "_full"}, tx_full, tx_q.size() == DEPTH);
    chk({tag, "_empty"}, rx_empty, rx_q.size() == 0);
    chk({tag, "_ovr"}, overrun, ovr_m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  bad;

    vecs[0] = '{1'b1, 2, 2, 0, 2, 1'b0};
    vecs[1] = '{1'b0, 1, 1, 0, 3, 1'b0};
    vecs[2] = '{1'b0, 2, 2, 0, 4, 1'b1};
    vecs[3] = '{1'b1, 0, 0, 0, 0, 1'b0};
    vecs[4] = '{1'b0, 4, 0, 4, 0, 1'b0};
    vecs[5] = '{1'b0, 1, 3, 1, 3, 1'b0};
    vecs[6] = '{1'b0, 2, 1, 2, 4, 1'b0};
    vecs[7] = '{1'b0, 0, 2, 0, 4, 1'b1};

    rst = 1'b1; tx_data = 8'h00; tx_wr = 1'b0; rx_rd = 1'b0; start = 1'b0;
    len = 8'h00; flush = 1'b0; spi_datao = 8'h00; spi_done = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {ssn, busy, done, overrun, spi_go}, 5'b10000);
    chk("rst_datai", spi_datai, 8'h00);
    chk("rst_tx", {tx_full, tx_level}, 4'b0000);
    chk("rst_rx", {rx_empty, rx_level}, 4'b1000);
    chk("rst_rxdata", rx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-byte burst, push/pop in the same cycle, start/flush ignored while busy.
    push_tx(8'hA5); push_tx(8'h3C); push_tx(8'h77);
    chk("seq1_txl", tx_level, 3);
    pulse_start(2);
    chk("e1_flags", {ssn, busy, spi_go}, 3'b010);
    tx_wr = 1'b1; tx_data = 8'h11;
    @(negedge clk);
    tx_wr = 1'b0;
    tx_q.push_back(8'h11);
    chk("e2_go", spi_go, 1'b1);
    chk("pushpop_lvl", tx_level, 3);
    start = 1'b1; len = 8'd7; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    serve(1'b0, 1);
    wait_go(n);
    chk("go_lat", n, 1);
    if (n < 40) serve(1'b1, 2);
    chk("seq1_txl_after", tx_level, 2);
    pop_rx(); pop_rx();
    chk("seq1_rx_empty", rx_empty, 1'b1);
    check_state("seq1");

    // Underrun stall: only one byte available for a three-byte burst.
    do_flush();
    push_tx(8'h81);
    pulse_start(3);
    wait_go(n);
    chk("go_lat", n, 1);
    serve(1'b0, 1);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bad |= spi_go | ssn | ~busy;
    end
    chk("stall", bad, 1'b0);
    push_tx(8'h42); push_tx(8'h24);
    wait_go(n);
    chk("stall_resume", n < 40, 1'b1);
    serve(1'b0, 1);
    wait_go(n);
    chk("go_lat", n, 1);
    if (n < 40) serve(1'b1, 2);
    chk("stall_rxl", rx_level, 3);
    check_state("stall");

    // Table-driven burst scenarios (cumulative state between rows).
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_flush) do_flush();
      for (int k = 0; k < vecs[i].npush; k++) push_tx(8'($urandom));
      if (vecs[i].blen > 0) burst(vecs[i].blen);
      else len0_check();
      chk($sformatf("vec%0d_txl", i), tx_level, vecs[i].exp_txl);
      chk($sformatf("vec%0d_rxl", i), rx_level, vecs[i].exp_rxl);
      chk($sformatf("vec%0d_ovr", i), overrun, vecs[i].exp_ovr);
    end
    while (rx_q.size() > 0) pop_rx();
    check_state("vec_drain");

    // Randomized operation mix against the model.
    for (int it = 0; it < 80; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        repeat ($urandom_range(1, 3)) push_tx(8'($urandom));
      end else if (op <= 4) begin
        repeat ($urandom_range(1, 3)) pop_rx();
      end else if (op <= 7) begin
        if (tx_q.size() > 0) burst($urandom_range(1, tx_q.size()));
        else push_tx(8'($urandom));
      end else if (op == 8) begin
        do_flush();
      end else begin
        len0_check();
      end
      check_state("rnd");
    end

    // Reset in the middle of a byte, then a stray spi_done after release.
    do_flush();
    push_tx(8'h5A); push_tx(8'hC3);
    pulse_start(2);
    wait_go(n);
    chk("go_lat", n, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", {ssn, busy, spi_go}, 3'b100);
    chk("mid_rst_fifo", {tx_level, rx_empty}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    spi_datao = 8'h55; spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    @(negedge clk);
    chk("late_done", {rx_level, busy, spi_go}, 5'b00000);
    check_state("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
